// File: rtl/vga_text_fetch.sv
// Text-mode character fetch: text RAM word -> font ROM row -> 8-pixel serializer,
// with active/hsync/vsync delayed 3 pixels to match. Define VGA_CURSOR_EN for the cursor overlay.
module vga_text_fetch #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int BLINK_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pix_ce_i,
  input  logic [9:0]  hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic        active_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [11:0] text_addr_o,
  output logic        text_en_o,
  input  logic [15:0] text_data_i,
  output logic [11:0] rom_addr_o,
  output logic        rom_en_o,
  input  logic [7:0]  rom_data_i,
  input  logic [6:0]  cursor_col_i,
  input  logic [4:0]  cursor_row_i,
  output logic [3:0]  pix_color_o,
  output logic        active_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam logic [11:0] COLS_W = 12'(COLS);
  localparam logic [5:0]  ROWS_W = 6'(ROWS);

  logic [4:0] row;
  logic [6:0] col;
  logic       cell_start;
  logic       row_vis;

  logic       s1_valid_q;
  logic       s1_fetch_q;
  logic [3:0] s1_line_q;
  logic       s2_valid_q;
  logic       s2_fetch_q;
  logic [7:0] attr_q;

  logic [7:0] shift_q, shift_d;
  logic [3:0] fg_q, fg_d;
  logic [3:0] bg_q, bg_d;
  logic       blink_q, blink_d;
  logic [BLINK_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] act_q, hs_q, vs_q;
  logic       cur_force;
  logic [3:0] pix_sel;
  logic       unused_bits;

  assign row        = vcount_i[8:4];
  assign col        = hcount_i[9:3];
  assign cell_start = active_i && (hcount_i[2:0] == 3'd0);
  assign row_vis    = ({1'b0, row} < ROWS_W);

  // Enables are qualified by pix_ce_i so each lasts one clock and the memory
  // samples it on the same edge that advances the pipeline.
  assign text_en_o   = rst_n_i && pix_ce_i && cell_start && row_vis;
  assign text_addr_o = text_en_o ? (12'(row) * COLS_W + 12'(col)) : 12'd0;
  assign rom_en_o    = pix_ce_i && s1_fetch_q;
  assign rom_addr_o  = rom_en_o ? {text_data_i[7:0], s1_line_q} : 12'd0;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    shift_d     = {shift_q[6:0], 1'b0};
    fg_d        = fg_q;
    bg_d        = bg_q;
    blink_d     = blink_q;
    frame_cnt_d = frame_cnt_q;
    if (s2_valid_q) begin
      // Blank rows load an all-zero cell so they render as background 0.
      shift_d = s2_fetch_q ? rom_data_i : 8'h00;
      fg_d    = attr_q[3:0];
      bg_d    = {1'b0, attr_q[6:4]};
      blink_d = attr_q[7];
    end
    if (vsync_i && !vs_q[0]) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_fetch_q  <= 1'b0;
      s1_line_q   <= 4'h0;
      s2_valid_q  <= 1'b0;
      s2_fetch_q  <= 1'b0;
      attr_q      <= 8'h00;
      shift_q     <= 8'h00;
      fg_q        <= 4'h0;
      bg_q        <= 4'h0;
      blink_q     <= 1'b0;
      frame_cnt_q <= '0;
      act_q       <= 3'b000;
      hs_q        <= 3'b000;
      vs_q        <= 3'b000;
    end else if (pix_ce_i) begin
      // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
      s1_valid_q  <= cell_start;
      s1_fetch_q  <= cell_start && row_vis;
      s1_line_q   <= vcount_i[3:0];
      s2_valid_q  <= s1_valid_q;
      s2_fetch_q  <= s1_fetch_q;
      attr_q      <= s1_fetch_q ? text_data_i[15:8] : 8'h00;
      shift_q     <= shift_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      blink_q     <= blink_d;
      frame_cnt_q <= frame_cnt_d;
      act_q       <= {act_q[1:0], active_i};
      hs_q        <= {hs_q[1:0], hsync_i};
      vs_q        <= {vs_q[1:0], vsync_i};
    end
  end

`ifdef VGA_CURSOR_EN
  logic cur_hit;
  logic cur1_q, cur2_q, cursor_q;

  assign cur_hit = cell_start && row_vis && (col == cursor_col_i) &&
                   (row == cursor_row_i) && (vcount_i[3:0] >= 4'd14);

  // Cursor flag rides the same S1/S2 stages as the cell it belongs to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur1_q   <= 1'b0;
      cur2_q   <= 1'b0;
      cursor_q <= 1'b0;
    end else if (pix_ce_i) begin
      cur1_q <= cur_hit;
      cur2_q <= cur1_q;
      if (s2_valid_q) cursor_q <= cur2_q;
    end
  end

  assign cur_force   = cursor_q && frame_cnt_q[BLINK_BITS-2];
  assign unused_bits = vcount_i[9];
`else
  assign cur_force   = 1'b0;
  assign unused_bits = ^{vcount_i[9], cursor_col_i, cursor_row_i};
`endif

  always_comb begin
    pix_sel = shift_q[7] ? fg_q : bg_q;
    if (blink_q && frame_cnt_q[BLINK_BITS-1]) pix_sel = bg_q;
    if (cur_force) pix_sel = fg_q;
  end

  assign pix_color_o = act_q[2] ? pix_sel : 4'h0;
  assign active_o    = act_q[2];
  assign hsync_o     = hs_q[2];
  assign vsync_o     = vs_q[2];

endmodule

// File: tb/tb_vga_text_fetch.sv
// Randomized self-checking bench for vga_text_fetch: a per-pixel reference model derived
// from the text/font memory contents predicts enables, addresses, colours and delayed syncs.
module tb_vga_text_fetch;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int BB   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic        active = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic [11:0] text_addr, rom_addr;
  logic        text_en, rom_en;
  logic [15:0] text_data = '0;
  logic [7:0]  rom_data = '0;
  logic [6:0]  cursor_col = 7'd3;
  logic [4:0]  cursor_row = 5'd2;
  logic [3:0]  pix_color;
  logic        active_o, hsync_o, vsync_o;

  always #5 clk = ~clk;

  vga_text_fetch #(.COLS(COLS), .ROWS(ROWS), .BLINK_BITS(BB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pix_ce_i(pix_ce),
    .hcount_i(hcount), .vcount_i(vcount), .active_i(active),
    .hsync_i(hsync), .vsync_i(vsync),
    .text_addr_o(text_addr), .text_en_o(text_en), .text_data_i(text_data),
    .rom_addr_o(rom_addr), .rom_en_o(rom_en), .rom_data_i(rom_data),
    .cursor_col_i(cursor_col), .cursor_row_i(cursor_row),
    .pix_color_o(pix_color), .active_o(active_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  // Synchronous text RAM and font ROM: data valid one clock after the enable.
  logic [15:0] tmem [4096];
  logic [7:0]  fmem [4096];
  always @(posedge clk) begin
    if (text_en) text_data <= tmem[text_addr];
    if (rom_en)  rom_data  <= fmem[rom_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 blanking, 1 pixel of a fetched cell, 2 partial cell after reset (black), 3 unspecified
  typedef struct {
    bit         act, hs, vs;
    logic [9:0] h, v;
    int         kind;
  } ent_t;

  ent_t hist[$];
  int   fc = 0;
  bit   vs_prev = 0, cell_ok = 0, loaded = 0;
  int   cap_v = -1, cap_col = -1;
  logic [3:0] cap [8];

  function automatic logic [3:0] exp_pix(input ent_t e);
    int row, col, p;
    logic [15:0] w;
    logic [7:0]  g;
    logic [3:0]  fg, bg;
    row = int'(e.v[8:4]);
    col = int'(e.h[9:3]);
    p   = int'(e.h[2:0]);
    if (row >= ROWS) return 4'h0;
    w  = tmem[row * COLS + col];
    g  = fmem[{w[7:0], e.v[3:0]}];
    fg = w[11:8];
    bg = {1'b0, w[14:12]};
`ifdef VGA_CURSOR_EN
    if (col == int'(cursor_col) && row == int'(cursor_row) && e.v[3:0] >= 4'd14 && fc[BB-2])
      return fg;
`endif
    if (w[15] && fc[BB-1]) return bg;
    return g[7-p] ? fg : bg;
  endfunction

  // One clock: drive at negedge, check enables, advance model at posedge, check outputs at next negedge.
  task automatic tick(input bit ce, input bit rst, input bit act, input bit hs, input bit vs,
                      input logic [9:0] h, input logic [9:0] v);
    ent_t e, src;
    bit exp_ten, exp_ren;
    logic [15:0] w;
    logic [3:0] expc;
    rst_n = rst; pix_ce = ce; active = act; hsync = hs; vsync = vs; hcount = h; vcount = v;
    #1;
    exp_ten = rst && ce && act && (h[2:0] == 3'd0) && (int'(v[8:4]) < ROWS);
    check("text_en", {31'd0, text_en}, {31'd0, exp_ten});
    if (exp_ten) check("text_addr", {20'd0, text_addr}, int'(v[8:4]) * COLS + int'(h[9:3]));
    exp_ren = 0;
    if (rst && ce && hist.size() > 0) begin
      src = hist[hist.size()-1];
      exp_ren = src.act && (src.h[2:0] == 3'd0) && (int'(src.v[8:4]) < ROWS);
    end
    check("rom_en", {31'd0, rom_en}, {31'd0, exp_ren});
    if (exp_ren) begin
      w = tmem[int'(src.v[8:4]) * COLS + int'(src.h[9:3])];
      check("rom_addr", {20'd0, rom_addr}, {20'd0, w[7:0], src.v[3:0]});
    end

    @(posedge clk);
    if (!rst) begin
      hist.delete();
      fc = 0; vs_prev = 0; cell_ok = 0; loaded = 0;
    end else if (ce) begin
      if (vs && !vs_prev) fc = (fc + 1) % (1 << BB);
      vs_prev = vs;
      e.act = act; e.hs = hs; e.vs = vs; e.h = h; e.v = v;
      if (!act) begin cell_ok = 0; e.kind = 0; end
      else if (h[2:0] == 3'd0) begin cell_ok = 1; loaded = 1; e.kind = 1; end
      else if (cell_ok) e.kind = 1;
      else if (!loaded) e.kind = 2;
      else e.kind = 3;
      hist.push_back(e);
      if (hist.size() > 4) void'(hist.pop_front());
    end

    @(negedge clk);
    if (hist.size() >= 3) src = hist[hist.size()-3];
    else begin
      src.act = 0; src.hs = 0; src.vs = 0; src.h = '0; src.v = '0; src.kind = 0;
    end
    check("active_o", {31'd0, active_o}, {31'd0, src.act});
    check("hsync_o",  {31'd0, hsync_o},  {31'd0, src.hs});
    check("vsync_o",  {31'd0, vsync_o},  {31'd0, src.vs});
    if (src.kind != 3) begin
      expc = (src.kind == 1) ? exp_pix(src) : 4'h0;
      check("pix_color", {28'd0, pix_color}, {28'd0, expc});
    end
    if (src.kind == 1 && int'(src.v) == cap_v && int'(src.h[9:3]) == cap_col)
      cap[src.h[2:0]] = pix_color;
  endtask

  // Active run of npix pixels from h0, then a short blanking tail carrying hsync.
  // mode: 0 pix_ce every clock, 1 pix_ce one clock in four, 2 random pix_ce.
  task automatic run_line(input int v, input int h0, input int npix, input int mode);
    int i = 0, k = 0, h = h0;
    bit ce;
    while (i < npix + 6) begin
      case (mode)
        0:       ce = 1'b1;
        1:       ce = (k % 4 == 0);
        default: ce = ($urandom_range(0, 3) != 0);
      endcase
      tick(ce, 1'b1, i < npix, (i >= npix + 1) && (i < npix + 4), 1'b0, 10'(h), 10'(v));
      if (ce) begin i++; h++; end
      k++;
    end
  endtask

  task automatic vpulses(input int n);
    for (int j = 0; j < n; j++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd500);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd500);
    end
  endtask

  task automatic check_cap(input string tag, input logic [31:0] exp_row);
    for (int i = 0; i < 8; i++) check(tag, {28'd0, cap[i]}, {28'd0, exp_row[31-4*i -: 4]});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tmem[i] = 16'($urandom);
      fmem[i] = 8'($urandom);
    end
    tmem[2399]   = 16'h1F41;
    fmem[12'h415] = 8'hA0;

    @(negedge clk);
    // Reset held while the sync generator runs: everything stays quiet.
    for (int h = 0; h < 10; h++) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'(h), 10'd16);
    // Release mid-cell: fetching resumes at the next aligned cell only.
    for (int h = 10; h < 41; h++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'(h), 10'd16);
    for (int h = 41; h < 47; h++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'(h), 10'd16);

    // Last column of last row, font line 5: address 2399, ROM 0x415, glyph 1010_0000.
    cap_v = 29 * 16 + 5; cap_col = 79;
    for (int i = 0; i < 8; i++) cap[i] = 4'hx;
    run_line(29 * 16 + 5, 624, 16, 0);
    check_cap("serialize", 32'hF1F1_1111);

    // Blinking attribute: blank at frame 32, visible again after wrap to 0.
    tmem[2399] = 16'h9F41;
    vpulses(32);
    for (int i = 0; i < 8; i++) cap[i] = 4'hx;
    run_line(29 * 16 + 5, 624, 16, 0);
    check_cap("blink_on", 32'h1111_1111);
    vpulses(32);
    for (int i = 0; i < 8; i++) cap[i] = 4'hx;
    run_line(29 * 16 + 5, 624, 16, 0);
    check_cap("blink_wrap", 32'hF1F1_1111);

    // One-in-four pixel enable: same pixel sequence, each value held between enables.
    for (int i = 0; i < 8; i++) cap[i] = 4'hx;
    run_line(29 * 16 + 5, 624, 16, 1);
    check_cap("ce_quarter", 32'hF1F1_1111);
    cap_col = -1;

    // Cursor cell (3,2), font rows 14-15, with frame_cnt[4] set.
    vpulses(16);
    run_line(2 * 16 + 15, 0, 48, 0);
    run_line(2 * 16 + 14, 0, 48, 2);

    // Blank rows and a misaligned start.
    run_line(30 * 16 + 3, 0, 24, 0);
    run_line(100, 5, 30, 0);

    for (int n = 0; n < 24; n++) begin
      int v, h0;
      v  = $urandom_range(0, 511);
      h0 = $urandom_range(0, 68) * 8;
      if ($urandom_range(0, 4) == 0) h0 = h0 + $urandom_range(1, 7);
      run_line(v, h0, $urandom_range(8, 80), $urandom_range(0, 2));
      vpulses($urandom_range(0, 12));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_text_fetch.md
Name: vga_text_fetch

Overview:
Text-mode character fetch sequencer for the VGA controller. Per 8-pixel character cell, it reads the {attribute, char} word from text RAM, then the font row from the 4K x 8 synchronous font ROM (256 chars x 16 rows, address {char, row[3:0]}). It serializes the font row into a 4-bit colour index and delays sync/active to match. It sits between the sync generator and the palette/DAC stage.

Parameters:
COLS, 80, character columns per line (text address stride)
ROWS, 30, character rows per frame; rows >= ROWS output background 0
BLINK_BITS, 6, width of frame counter; MSB is the attribute blink phase

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
pix_ce_i  input  1  pixel clock enable; all pipeline advances gated by it
hcount_i  input  10  pixel column from sync generator
vcount_i  input  10  pixel line from sync generator
active_i  input  1  visible-area flag
hsync_i  input  1  horizontal sync, active-high
vsync_i  input  1  vertical sync, active-high
text_addr_o  output  12  text RAM address
text_en_o  output  1  text RAM read enable
text_data_i  input  16  {attr[7:0], char[7:0]}, valid 1 clk after text_en_o
rom_addr_o  output  12  font ROM address {char, vcount[3:0]}
rom_en_o  output  1  font ROM enable
rom_data_i  input  8  font row, MSB = leftmost pixel, valid 1 clk after rom_en_o
cursor_col_i  input  7  cursor column (VGA_CURSOR_EN only)
cursor_row_i  input  5  cursor row (VGA_CURSOR_EN only)
pix_color_o  output  4  colour index
active_o  output  1  delayed active
hsync_o  output  1  delayed hsync
vsync_o  output  1  delayed vsync

Behaviour:
- Reset (async, rst_n_i=0): all outputs 0, pipeline valid bits 0, shift register 0, frame counter 0. Reset mid-line: first valid cell after release is the next cell start; no partial cell is output.
- All registers update only on clk_i edges with pix_ce_i=1, except the async reset.
- Stage S0 (cell start: active_i=1, hcount_i[2:0]=0): text_addr_o = vcount_i[8:4]*COLS + hcount_i[9:3]; text_en_o=1 for that single clock only.
- Stage S1 (next pix_ce): capture attr; rom_addr_o = {text_data_i[7:0], vcount_d1[3:0]}; rom_en_o=1 for that single clock only.
- Stage S2 (next pix_ce): load 8-bit shift register from rom_data_i. Latch fg=attr[3:0], bg={1'b0,attr[6:4]}, blink=attr[7].
- S3 onward: shift left once per pix_ce. Output pixel = MSB ? fg : bg.
- Latency: pix_color_o/active_o/hsync_o/vsync_o lag inputs by exactly 3 pix_ce cycles. Cell pixel 0 appears 3 pixels after hcount_i[2:0]=0.
- active_o=0: pix_color_o=0. vcount_i[8:4] >= ROWS: pix_color_o=bg 0, no RAM/ROM enables.
- Text address arithmetic: 12-bit unsigned. Max 29*80+79 = 2399, no wrap.
- Frame counter: increments on rising edge of vsync_i (sampled under pix_ce); wraps 2^BLINK_BITS-1 -> 0.
- Blink: blink=1 and frame_cnt MSB=1 -> all cell pixels = bg.
- hcount_i[2:0]!=0 at active_i rise (misaligned timing): no fetch until next aligned cell. Shift register outputs bg.
- pix_ce_i=0: all state holds; enables deassert.

Optional Feature:
VGA_CURSOR_EN: defined -> cell with col==cursor_col_i and row==cursor_row_i, font rows 14-15 (vcount[3:0]>=14), with frame_cnt[BLINK_BITS-2]=1: all pixels forced to fg, overriding attribute blink. Undefined -> cursor ports present but ignored, no cursor logic synthesized.

Test Plan:
- Reset: hold rst_n_i=0 with active stimulus -> all outputs 0, no enables. Release -> first text_en_o at next hcount[2:0]=0.
- Address: hcount=640-8 (col 79), vcount=29*16 -> text_addr_o=2399. Then text_data={8'h1F,8'h41}, vcount[3:0]=5 -> rom_addr_o=12'h415.
- Serialization: rom_data=8'b1010_0000, attr=8'h1F -> pix_color_o = F,1,F,1,1,1,1,1, starting 3 pix_ce after cell start. hsync_o/vsync_o delayed exactly 3.
- Blink: attr=8'h9F; after 32 vsync rising edges (frame_cnt=32) -> whole cell = 1; after 64 (wrap to 0) -> glyph shown again.
- pix_ce gating: pix_ce_i toggling 1-of-4 -> identical pixel sequence, each value held 4 clocks.
- VGA_CURSOR_EN: cursor (3,2), vcount=2*16+15, frame_cnt[4]=1 -> cell 3 row 15 all fg. Without macro -> font data unchanged.
